uart_rx_mmio: RTL and testbench
===============================

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 SHALL have parameter BASE, default 32'hffff0010, base address of the 16-byte register window.
REQ-002 SHALL have parameter DEPTH, default 16, RX FIFO depth in bytes (power of two).
REQ-003 SHALL have parameter DIV_RST, default 16'd868, reset value of the bit-period divisor in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port xreset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port d_adr  input  32  core data address.
REQ-007 SHALL have port d_re  input  1  core read enable.
REQ-008 SHALL have port d_we  input  4  core byte write enables.
REQ-009 SHALL have port d_dw  input  32  core write data.
REQ-010 SHALL have port d_dr  output  32  registered read data.
REQ-011 SHALL have port d_sel  output  1  d_dr valid this cycle, used by the top-level read mux.
REQ-012 SHALL have port rxd  input  1  asynchronous serial input, idle high.
REQ-013 SHALL have port irq  output  1  interrupt request.

Function
REQ-014 SHALL decode hit = (d_adr[31:4] == BASE[31:4]); offsets: 0x0 RXDATA, 0x4 STATUS, 0x8 DIV; other offsets read 0, ignore writes.
REQ-015 SHALL register reads: on a hit with d_re in cycle N, d_sel=1 and d_dr valid in cycle N+1; otherwise d_sel=0 and d_dr=0.
REQ-016 SHALL return {24'b0, FIFO head} for an RXDATA read and pop the FIFO in cycle N; if empty, return 0 with no pop.
REQ-017 SHALL return STATUS = {bits[12:8]=count, bit3=frame_err, bit2=overrun, bit1=full, bit0=not_empty}, all other bits 0.
REQ-018 SHALL clear overrun when STATUS is written with d_we[0]=1 and d_dw[2]=1, and clear frame_err when d_dw[3]=1; other bits are read-only.
REQ-019 SHALL update DIV[7:0] on d_we[0] and DIV[15:8] on d_we[1]; a resulting value below 4 SHALL be stored as 4; DIV reads back zero-extended.
REQ-020 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-021 SHALL implement FSM IDLE, START, DATA, STOP; IDLE -> START on synchronized rxd=0, loading bit counter with DIV/2.
REQ-022 SHALL, in START at counter expiry, sample rxd: 0 -> DATA (counter=DIV), 1 -> IDLE (glitch rejected, nothing recorded).
REQ-023 SHALL, in DATA, sample one bit every DIV cycles, LSB first, 8 bits, then -> STOP with counter=DIV.
REQ-024 SHALL, in STOP at counter expiry, push the byte if rxd=1, else set frame_err and discard the byte; then -> IDLE.
REQ-025 SHALL drop the byte and set overrun when a push occurs with FIFO full; FIFO contents unchanged.
REQ-026 SHALL perform both on simultaneous push and pop with FIFO non-empty, count unchanged; with FIFO empty the pop returns 0 and the push lands (count=1).
REQ-027 SHALL apply a DIV write at the next counter load; a bit period in progress completes with the old value.
REQ-028 SHALL drive irq = not_empty | overrun | frame_err, registered.

Reset
REQ-029 SHALL, while xreset=0 at a clk edge, set d_dr=0, d_sel=0, irq=0, FIFO empty, count=0, overrun=0, frame_err=0, FSM=IDLE, DIV=DIV_RST, synchronizer flops=1.
REQ-030 SHALL discard any partially received byte on reset; no push after release.

Verification
REQ-031 SHALL cover: write DIV=8, send frame 0x55 -> STATUS reads 0x0000_0101, then RXDATA reads 0x55, then STATUS reads 0x0.
REQ-032 SHALL cover: send bytes 0x00..0x10 unread (DEPTH=16) -> STATUS 0x0000_1007; 16 RXDATA reads return 0x00..0x0F; write STATUS 0x4 clears overrun.
REQ-033 SHALL cover: frame 0xA3 with stop bit 0 -> STATUS 0x0000_0008, FIFO empty, irq=1; write STATUS 0x8 -> STATUS 0x0, irq=0.
REQ-034 SHALL cover: rxd low for 2 cycles with DIV=8 -> FSM returns to IDLE, STATUS stays 0x0.
REQ-035 SHALL cover: count=1, RXDATA read in the same cycle as the STOP push -> read returns old head, count remains 1.
REQ-036 SHALL cover: xreset asserted mid-DATA after DIV=8 write -> after release DIV reads 868, STATUS 0x0, no byte pushed.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 2-flop rxd synchronizer, mid-bit sampling FSM,
// byte FIFO and a 16-byte register window (RXDATA / STATUS / DIV) with registered reads.
module uart_rx_mmio #(
    parameter logic [31:0] BASE    = 32'hffff0010,
    parameter int          DEPTH   = 16,
    parameter logic [15:0] DIV_RST = 16'd868
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [31:0] d_adr,
    input  logic        d_re,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_dw,
    output logic [31:0] d_dr,
    output logic        d_sel,
    input  logic        rxd,
    output logic        irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state;
    logic [15:0]   r_div;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          r_overrun, r_frame_err;
    logic [31:0]   r_dr;
    logic          r_sel, r_irq;

    logic          w_rxd, w_expire, w_stop_done, w_push_req, w_frame_bad;
    logic          w_hit, w_rd, w_pop, w_push, w_ovr_set, w_full, w_not_empty;
    logic          w_stat_wr, w_div_wr;
    logic [3:0]    w_off;
    logic [15:0]   w_div_merge;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_rxd       = r_sync2;
    assign w_expire    = (r_cnt <= 16'd1);
    assign w_stop_done = (r_state == S_STOP) && w_expire;
    assign w_push_req  = w_stop_done && w_rxd;
    assign w_frame_bad = w_stop_done && !w_rxd;

    assign w_hit       = (d_adr[31:4] == BASE[31:4]);
    assign w_off       = d_adr[3:0];
    assign w_rd        = w_hit && d_re;
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = w_rd && (w_off == 4'h0) && w_not_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovr_set   = w_push_req && w_full && !w_pop;
    assign w_stat_wr   = w_hit && (w_off == 4'h4) && d_we[0];
    assign w_div_wr    = w_hit && (w_off == 4'h8) && (d_we[0] || d_we[1]);
    assign w_status    = {19'b0, 5'(r_count), 4'b0, r_frame_err, r_overrun, w_full, w_not_empty};
    assign w_unused    = ^{d_we[3:2], d_dw[31:16]};

    always_comb begin
        w_div_merge = r_div;
        if (d_we[0]) w_div_merge[7:0]  = d_dw[7:0];
        if (d_we[1]) w_div_merge[15:8] = d_dw[15:8];
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Counter expires when it reaches 1, so a load of N spans exactly N cycles.
    always_ff @(posedge clk) begin
        if (!xreset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd) begin
                        r_state <= S_START;
                        r_cnt   <= {1'b0, r_div[15:1]};
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        r_cnt  <= r_div;
                        r_bitn <= '0;
                        r_state <= w_rxd ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift <= {w_rxd, r_shift[7:1]};
                        r_cnt   <= r_div;
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_expire) r_state <= S_IDLE;
                    else          r_cnt   <= r_cnt - 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_div       <= DIV_RST;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= w_not_empty | r_overrun | r_frame_err;
            if (w_stat_wr && d_dw[2]) r_overrun   <= 1'b0;
            if (w_stat_wr && d_dw[3]) r_frame_err <= 1'b0;
            if (w_ovr_set)            r_overrun   <= 1'b1;
            if (w_frame_bad)          r_frame_err <= 1'b1;
            if (w_div_wr) r_div <= (w_div_merge < 16'd4) ? 16'd4 : w_div_merge;
        end
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            r_dr  <= '0;
            r_sel <= 1'b0;
        end else begin
            r_sel <= w_rd;
            r_dr  <= '0;
            if (w_rd) begin
                case (w_off)
                    4'h0:    r_dr <= w_not_empty ? {24'b0, r_mem[r_rp]} : 32'b0;
                    4'h4:    r_dr <= w_status;
                    4'h8:    r_dr <= {16'b0, r_div};
                    default: r_dr <= '0;
                endcase
            end
        end
    end

    assign d_dr  = r_dr;
    assign d_sel = r_sel;
    assign irq   = r_irq;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomized bench for uart_rx_mmio: a queue-based model predicts d_sel/d_dr/irq
// every cycle, plus literal checks of the register scenarios.
`timescale 1ns/1ps
module tb_uart_rx_mmio;
    localparam logic [31:0] BASE    = 32'hffff0010;
    localparam int          DEPTH   = 16;
    localparam logic [15:0] DIV_RST = 16'd868;
    localparam logic [31:0] A_DATA  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'd4;
    localparam logic [31:0] A_DIV   = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        xreset = 1'b0;
    logic [31:0] d_adr = '0;
    logic        d_re = 1'b0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_dw = '0;
    logic [31:0] d_dr;
    logic        d_sel;
    logic        rxd = 1'b1;
    logic        irq;

    uart_rx_mmio #(.BASE(BASE), .DEPTH(DEPTH), .DIV_RST(DIV_RST)) dut (
        .clk(clk), .xreset(xreset), .d_adr(d_adr), .d_re(d_re), .d_we(d_we),
        .d_dw(d_dw), .d_dr(d_dr), .d_sel(d_sel), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Behavioural model state
    byte unsigned mq[$];
    bit           m_ovr = 1'b0, m_ferr = 1'b0;
    logic [15:0]  m_div = DIV_RST;
    bit           e_sel = 1'b0, e_irq = 1'b0;
    logic [31:0]  e_dr = '0;
    int           killed_cyc = -2;

    // Frame announced by the sender: lands in the FIFO at edge pend_cyc
    int           pend_cyc = -1;
    byte unsigned pend_byte = 8'h00;
    bit           pend_stop = 1'b1;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size()) << 8;
        s[3] = m_ferr;
        s[2] = m_ovr;
        s[1] = (mq.size() == DEPTH);
        s[0] = (mq.size() != 0);
        return s;
    endfunction

    always @(posedge clk) begin
        bit          pop;
        logic [15:0] nd;
        cyc++;
        pop = 1'b0;
        if (!xreset) begin
            mq.delete();
            m_ovr = 1'b0; m_ferr = 1'b0; m_div = DIV_RST;
            e_sel = 1'b0; e_dr = '0; e_irq = 1'b0;
            killed_cyc = pend_cyc;
        end else begin
            e_irq = (mq.size() != 0) || m_ovr || m_ferr;
            e_sel = 1'b0;
            e_dr  = '0;
            if (d_adr[31:4] == BASE[31:4]) begin
                if (d_re) begin
                    e_sel = 1'b1;
                    case (d_adr[3:0])
                        4'h0: if (mq.size() != 0) begin e_dr = {24'b0, mq[0]}; pop = 1'b1; end
                        4'h4: e_dr = m_status();
                        4'h8: e_dr = {16'b0, m_div};
                        default: e_dr = '0;
                    endcase
                end
                if (d_adr[3:0] == 4'h4 && d_we[0]) begin
                    if (d_dw[2]) m_ovr  = 1'b0;
                    if (d_dw[3]) m_ferr = 1'b0;
                end
                if (d_adr[3:0] == 4'h8 && (d_we[0] || d_we[1])) begin
                    nd = m_div;
                    if (d_we[0]) nd[7:0]  = d_dw[7:0];
                    if (d_we[1]) nd[15:8] = d_dw[15:8];
                    m_div = (nd < 16'd4) ? 16'd4 : nd;
                end
            end
            if (pop) void'(mq.pop_front());
            if (cyc == pend_cyc && pend_cyc != killed_cyc) begin
                if (!pend_stop)             m_ferr = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(pend_byte);
                else                        m_ovr = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic bus_idle();
        d_re = 1'b0; d_we = '0; d_adr = '0; d_dw = '0;
    endtask

    task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] exp);
        @(posedge clk); #1; bus_idle(); d_re = 1'b1; d_adr = a;
        @(posedge clk); #1; bus_idle();
        @(negedge clk);
        $display("rd %h -> %h (%s)", a, d_dr, nm);
        chk(nm, d_dr, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] dw);
        @(posedge clk); #1; bus_idle(); d_we = we; d_adr = a; d_dw = dw;
        @(posedge clk); #1; bus_idle();
        $display("wr %h = %h we %b", a, dw, we);
    endtask

    // rmode: 0 = bus quiet, 1 = random reads, 2 = RXDATA read on the push edge
    logic [31:0] land_dr;
    task automatic send_frame(input byte unsigned b, input bit stop, input int rmode);
        int d, land;
        logic [9:0] bits;
        d = int'(m_div);
        bits = {stop, b, 1'b0};
        @(posedge clk); #1;
        land = cyc + 3 + d / 2 + 9 * d;
        pend_byte = b; pend_stop = stop; pend_cyc = land;
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < d; k++) begin
                if (j != 0 || k != 0) begin @(posedge clk); #1; end
                if (rmode == 2 && cyc == land) land_dr = d_dr;
                rxd = bits[j];
                bus_idle();
                if (rmode == 2 && cyc + 1 == land) begin
                    d_re = 1'b1; d_adr = A_DATA;
                end else if (rmode == 1 && $urandom_range(7) == 0) begin
                    d_re = 1'b1; d_adr = BASE + 32'(4 * $urandom_range(3));
                end
            end
        end
        repeat (3) begin @(posedge clk); #1; bus_idle(); rxd = 1'b1; end
        $display("frame %h stop %b div %0d", b, stop, d);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (cyc > 0) begin
                    n_vec++;
                    if (d_sel !== e_sel || d_dr !== e_dr || irq !== e_irq) begin
                        n_err++;
                        $display("FAIL cycle %0d outputs: got sel=%b dr=%h irq=%b, expected sel=%b dr=%h irq=%b",
                                 cyc, d_sel, d_dr, irq, e_sel, e_dr, e_irq);
                    end
                end
            end
        join_none

        bus_idle();
        rxd = 1'b1;
        xreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 xreset = 1'b1;
        @(negedge clk);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_sel", {31'b0, d_sel}, 32'h0);
        rd(A_DIV, "div_reset", 32'd868);
        rd(A_STAT, "stat_reset", 32'h0);
        rd(BASE + 32'hC, "unmapped", 32'h0);

        wr(A_DIV, 4'b0011, 32'h0000_0002);
        rd(A_DIV, "div_clamp", 32'h4);
        wr(A_DIV, 4'b0010, 32'h0000_0100);
        rd(A_DIV, "div_lane1", 32'h104);

        // Single frame
        wr(A_DIV, 4'b0011, 32'd8);
        send_frame(8'h55, 1'b1, 0);
        rd(A_STAT, "stat_one", 32'h101);
        rd(A_DATA, "data_55", 32'h55);
        rd(A_STAT, "stat_empty", 32'h0);

        // Overflow
        for (int i = 0; i <= 16; i++) send_frame(byte'(i), 1'b1, 0);
        rd(A_STAT, "stat_full_ovr", 32'h1007);
        for (int i = 0; i < 16; i++) rd(A_DATA, "data_seq", 32'(i));
        rd(A_STAT, "stat_ovr_only", 32'h4);
        wr(A_STAT, 4'b0001, 32'h4);
        rd(A_STAT, "stat_ovr_clr", 32'h0);

        // Framing error
        send_frame(8'hA3, 1'b0, 0);
        rd(A_STAT, "stat_ferr", 32'h8);
        chk("irq_ferr", {31'b0, irq}, 32'h1);
        wr(A_STAT, 4'b0001, 32'h8);
        rd(A_STAT, "stat_ferr_clr", 32'h0);
        chk("irq_clr", {31'b0, irq}, 32'h0);

        // Glitch rejection
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        rd(A_STAT, "stat_glitch", 32'h0);

        // Read on the push edge
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 2);
        chk("rd_at_push", land_dr, 32'h11);
        rd(A_STAT, "stat_after_race", 32'h101);
        rd(A_DATA, "data_22", 32'h22);

        // Reset mid-DATA
        wr(A_DIV, 4'b0011, 32'd8);
        @(posedge clk); #1 rxd = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rxd = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        rxd = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        xreset = 1'b0; rxd = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        xreset = 1'b1;
        repeat (30) @(posedge clk);
        rd(A_DIV, "div_after_rst", 32'd868);
        rd(A_STAT, "stat_after_rst", 32'h0);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 0) wr(A_DIV, 4'b0011, 32'($urandom_range(20, 8)));
            if ($urandom_range(3) == 0) wr(A_STAT, 4'b0001, 32'($urandom_range(3)) << 2);
            send_frame(byte'($urandom_range(255)), ($urandom_range(9) != 0), 1);
        end
        for (int i = 0; i < DEPTH + 2; i++) rd(A_DATA, "drain", {24'b0, (mq.size() != 0) ? mq[0] : 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
